z80_int_ctrl: RTL and testbench
===============================

// Module: z80_int_ctrl
// PURPOSE
//  Interrupt source for the Z80 INT pin, which the glue CPLD currently ties high. Two sources:
//  - a 50 Hz frame timer;
//  - the 16550 U_INT.
//  Masking and status are reached through I/O ports next to system_port (0x20). The block
//  drives IM2 vectors onto D during the M1+IORQ acknowledge cycle. It runs in the CLK_24MHz
//  domain and samples Z80 strobes through synchronizers.
// PARAMETERS
//  TICK_DIV    480000  CLK_24MHz cycles per timer tick (24 MHz / 50 Hz); >= 2
//  MASK_PORT   8'h21   R/W: bit0 timer enable, bit1 uart enable, bits7:2 read 0
//  STAT_PORT   8'h22   R: bit0 timer pending, bit1 U_INT (synced); W: 1 to bit0 clears timer pending
//  OVR_PORT    8'h23   R: overrun count (only with INT_CTRL_OVERRUN_EN)
//  VECTOR_BASE 8'hF0   IM2 vector base, bits 2:0 must be 0
// PORTS
//  CLK_24MHz  in   1  main clock
//  RES        in   1  async active-low reset
//  A          in   8  cpu_address_l
//  D_in       in   8  Z80 data bus (input side)
//  D_out      out  8  data driven to bus
//  D_oe       out  1  1 = drive D_out onto D (top level makes D tri-state)
//  IORQ       in   1  Z80 IORQ_n
//  M1         in   1  Z80 M1_n
//  RD         in   1  Z80 RD_n
//  WR         in   1  Z80 WR_n
//  U_INT      in   1  16550 interrupt, active high, level
//  INT        out  1  Z80 INT_n, registered
// BEHAVIOUR
//  Reset (RES low, async):
//  - tick_cnt=0, timer_pend=0, mask=0, vec_sel=0, ovr=0; INT=1; D_oe=0; D_out=0.
//  - Sync flops reset to 1 (idle-high strobes).
//  Strobes:
//  - iowr_n=IORQ|WR, iord_n=IORQ|RD, inta_n=IORQ|M1.
//  - Each strobe passes a 2-FF synchronizer; edges are detected on the synced value.
//  Register write:
//  - Fires on synced iowr_n falling edge, 2-3 clocks after WR falls.
//  - A and D_in are sampled that same cycle; the Z80 I/O write low time is >= 4 clocks at <= 12 MHz.
//  Reads and vector drive (combinational, from raw strobes, mirroring the decoder's read path):
//  - D_oe = (~iord_n & A in {MASK,STAT[,OVR]}) | (~inta_n).
//  - inta: D_out = VECTOR_BASE | {vec_sel,1'b0}.
//  - Else D_out = selected register.
//  Timer:
//  - tick_cnt counts 0..TICK_DIV-1 and wraps.
//  - tick=1 in the cycle tick_cnt==TICK_DIV-1; tick sets timer_pend.
//  - The timer runs regardless of mask.
//  Request and INT:
//  - req[0]=timer_pend&mask[0]; req[1]=u_int_sync&mask[1]; U_INT has its own 2-FF sync.
//  - INT <= ~|req every clock, giving 1 clock latency from the req change.
//  Vector select:
//  - While raw inta_n=1, vec_sel <= req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd3 (timer has priority; 3 = spurious).
//  - Held while raw inta_n=0, so the vector is stable for the whole ack cycle.
//  Acknowledge:
//  - On synced inta_n rising edge with vec_sel==0, timer_pend <= 0.
//  - UART is level-based: it clears only when the 16550 drops U_INT.
//  Simultaneous events and edge cases:
//  - tick in the same cycle as an ack-clear or a W1C: tick wins, timer_pend stays 1.
//  - Mask cleared while pending: pending is kept and INT deasserts next clock. Re-enabling reasserts INT.
//  - Write to STAT bit1 or bits7:2: ignored.
//  - Reset mid ack cycle: D_oe drops immediately; no clear is recorded.
// CONFIGURATION
//  INT_CTRL_OVERRUN_EN defined:
//  - ovr is a 4-bit saturating counter, incremented when tick arrives while timer_pend=1 (max 15).
//  - Read at OVR_PORT as {4'b0,ovr}.
//  - ovr clears on the synced iord_n rising edge of an OVR_PORT read; a same-cycle increment is lost (clear wins).
//  INT_CTRL_OVERRUN_EN undefined:
//  - No counter exists; OVR_PORT is not decoded and D_oe stays 0 for it.
// TESTING
//  Test benches use TICK_DIV=16.
//  1. Reset, then OUT (0x21),0x01; run 16 clks
//     -> timer_pend=1 and INT=0 one clk after tick; IN (0x22) returns 0x01.
//  2. Pending timer, M1+IORQ ack cycle
//     -> D_oe=1, D_out=0xF0 throughout; after IORQ rises, timer_pend=0 and INT=1 within 4 clks.
//  3. mask=0x03, U_INT=1, timer pending, ack
//     -> vector 0xF0; second ack -> 0xF2; INT stays 0 until U_INT=0.
//  4. Pending timer, OUT (0x21),0x00
//     -> INT=1; OUT (0x21),0x01 -> INT=0 again; OUT (0x22),0x01 -> pending cleared.
//  5. Align W1C of STAT with the tick cycle
//     -> timer_pend remains 1 (tick wins).
//  6. EN build: 3 ticks with no ack -> IN (0x23)=0x02, next read 0x00; 20 missed ticks -> 0x0F.
//     Non-EN build: IN (0x23) -> D_oe=0.

Source files
------------

// File: rtl/z80_int_ctrl.sv
// z80_int_ctrl: 50 Hz timer and 16550 interrupt source for Z80 INT_n, IM2 vectors.
// Define INT_CTRL_OVERRUN_EN to add the missed-tick counter at OVR_PORT.

module z80_int_ctrl #(
    parameter int unsigned TICK_DIV    = 480000,
    parameter logic [7:0]  MASK_PORT   = 8'h21,
    parameter logic [7:0]  STAT_PORT   = 8'h22,
    parameter logic [7:0]  OVR_PORT    = 8'h23,
    parameter logic [7:0]  VECTOR_BASE = 8'hF0
) (
    input  logic       CLK_24MHz,
    input  logic       RES,
    input  logic [7:0] A,
    input  logic [7:0] D_in,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic       IORQ,
    input  logic       M1,
    input  logic       RD,
    input  logic       WR,
    input  logic       U_INT,
    output logic       INT
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    logic iowr_n, iord_n, inta_n;
    assign iowr_n = IORQ | WR;
    assign iord_n = IORQ | RD;
    assign inta_n = IORQ | M1;

    // bit0/bit1 form the 2-FF synchronizer, bit2 holds the previous synced value
    logic [2:0] wr_q, ia_q;
    logic [1:0] u_q;
    logic       wr_fall, ia_rise;
    assign wr_fall = ~wr_q[1] & wr_q[2];
    assign ia_rise = ia_q[1] & ~ia_q[2];

    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic          timer_pend_q, timer_pend_d;
    logic [7:0]    mask_q, mask_d;
    logic [1:0]    vec_sel_q, vec_sel_d;
    logic          int_q, int_d;
    logic          tick, w1c, ack_clr;
    logic [1:0]    req;

    assign tick    = (tick_cnt_q == TICK_LAST);
    assign w1c     = wr_fall & (A == STAT_PORT) & D_in[0];
    assign ack_clr = ia_rise & (vec_sel_q == 2'd0);
    assign req     = {u_q[1] & mask_q[1], timer_pend_q & mask_q[0]};

    always_comb begin
        tick_cnt_d   = tick ? '0 : tick_cnt_q + CW'(1);
        timer_pend_d = tick | (timer_pend_q & ~w1c & ~ack_clr);
        mask_d       = mask_q;
        if (wr_fall && (A == MASK_PORT)) begin
            mask_d = D_in & 8'h03;
        end
        int_d     = ~|req;
        vec_sel_d = vec_sel_q;
        if (inta_n) begin
            if (req[0]) begin
                vec_sel_d = 2'd0;
            end else if (req[1]) begin
                vec_sel_d = 2'd1;
            end else begin
                vec_sel_d = 2'd3;
            end
        end
    end

    always_ff @(posedge CLK_24MHz or negedge RES) begin
        if (!RES) begin
            wr_q         <= 3'b111;
            ia_q         <= 3'b111;
            u_q          <= 2'b00;
            tick_cnt_q   <= '0;
            timer_pend_q <= 1'b0;
            mask_q       <= 8'h00;
            vec_sel_q    <= 2'd0;
            int_q        <= 1'b1;
        end else begin
            wr_q         <= {wr_q[1:0], iowr_n};
            ia_q         <= {ia_q[1:0], inta_n};
            u_q          <= {u_q[0], U_INT};
            tick_cnt_q   <= tick_cnt_d;
            timer_pend_q <= timer_pend_d;
            mask_q       <= mask_d;
            vec_sel_q    <= vec_sel_d;
            int_q        <= int_d;
        end
    end

    logic       sel_ovr;
    logic [7:0] ovr_val;

`ifdef INT_CTRL_OVERRUN_EN
    logic [2:0] rd_q;
    logic       rd_fall, rd_rise;
    logic [3:0] ovr_q, ovr_d;
    logic       rd_ovr_q, rd_ovr_d;
    assign rd_fall = ~rd_q[1] & rd_q[2];
    assign rd_rise = rd_q[1] & ~rd_q[2];

    // address is latched at read start; it may already be gone when IORQ rises
    always_comb begin
        rd_ovr_d = rd_ovr_q;
        ovr_d    = ovr_q;
        if (rd_fall) begin
            rd_ovr_d = (A == OVR_PORT);
        end else if (rd_rise) begin
            rd_ovr_d = 1'b0;
        end
        if (rd_rise && rd_ovr_q) begin
            ovr_d = 4'h0;
        end else if (tick && timer_pend_q && (ovr_q != 4'hF)) begin
            ovr_d = ovr_q + 4'd1;
        end
    end

    always_ff @(posedge CLK_24MHz or negedge RES) begin
        if (!RES) begin
            rd_q     <= 3'b111;
            ovr_q    <= 4'h0;
            rd_ovr_q <= 1'b0;
        end else begin
            rd_q     <= {rd_q[1:0], iord_n};
            ovr_q    <= ovr_d;
            rd_ovr_q <= rd_ovr_d;
        end
    end

    assign sel_ovr = (A == OVR_PORT);
    assign ovr_val = {4'h0, ovr_q};
`else
    assign sel_ovr = (A == OVR_PORT) & 1'b0;
    assign ovr_val = 8'h00;
`endif

    always_comb begin
        D_oe  = 1'b0;
        D_out = 8'h00;
        if (RES) begin
            if (!inta_n) begin
                D_oe  = 1'b1;
                D_out = VECTOR_BASE | {5'b0, vec_sel_q, 1'b0};
            end else if (!iord_n) begin
                unique case (1'b1)
                    (A == MASK_PORT): begin
                        D_oe  = 1'b1;
                        D_out = mask_q;
                    end
                    (A == STAT_PORT): begin
                        D_oe  = 1'b1;
                        D_out = {6'b0, u_q[1], timer_pend_q};
                    end
                    sel_ovr: begin
                        D_oe  = 1'b1;
                        D_out = ovr_val;
                    end
                    default: begin
                        D_oe  = 1'b0;
                        D_out = 8'h00;
                    end
                endcase
            end
        end
    end

    assign INT = int_q;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Bench for z80_int_ctrl: edge-indexed event model checked every cycle,
// plus directed bus transactions with literal expectations.

module tb_z80_int_ctrl;

    localparam int TD = 16;
    localparam int N  = 8192;
`ifdef INT_CTRL_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       RES = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] D_in = 8'h00;
    logic [7:0] D_out;
    logic       D_oe;
    logic       IORQ = 1'b1;
    logic       M1 = 1'b1;
    logic       RD = 1'b1;
    logic       WR = 1'b1;
    logic       U_INT = 1'b0;
    logic       INT;

    z80_int_ctrl #(.TICK_DIV(TD)) dut (
        .CLK_24MHz(clk), .RES(RES), .A(A), .D_in(D_in),
        .D_out(D_out), .D_oe(D_oe), .IORQ(IORQ), .M1(M1),
        .RD(RD), .WR(WR), .U_INT(U_INT), .INT(INT)
    );

    always #5 clk = ~clk;

    // posedges seen since reset release
    int ecnt;
    always @(posedge clk or negedge RES) begin
        if (!RES) ecnt <= 0;
        else      ecnt <= ecnt + 1;
    end

    // model state after each edge
    bit       pm[N];
    bit [1:0] mm[N];
    bit       um[N];
    int       om[N];
    // events scheduled by the stimulus, indexed by the edge they land on
    bit       evw[N];
    bit [7:0] evwa[N];
    bit [7:0] evwd[N];
    bit       eva[N];
    int       evac[N];
    bit       evr[N];
    bit       evu[N];
    bit       evuv[N];

    int ack_c = 0;
    int npass = 0;
    int ntot  = 0;

    task automatic chk(string nm, int got, int exp);
        ntot++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // vector the controller must present for an ack that starts after edge c
    function automatic int vec_at(int c);
        int k;
        k = (c > 0) ? c - 1 : 0;
        if (pm[k] && mm[k][0]) return 0;
        if (um[k] && mm[k][1]) return 1;
        return 3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            evw[i] = 0; eva[i] = 0; evr[i] = 0; evu[i] = 0;
        end
    endtask

    task automatic model_step(int e);
        bit p, u;
        bit [1:0] m;
        int o;
        p = pm[e-1]; m = mm[e-1]; u = um[e-1]; o = om[e-1];
        if (evu[e]) u = evuv[e];
        if (evw[e]) begin
            if (evwa[e] == 8'h21) m = evwd[e][1:0];
            if (evwa[e] == 8'h22 && evwd[e][0]) p = 0;
        end
        if (eva[e] && vec_at(evac[e]) == 0) p = 0;
        if (e % TD == 0) begin
            if (pm[e-1] && o < 15) o++;
            p = 1;
        end
        if (evr[e]) o = 0;
        pm[e] = p; mm[e] = m; um[e] = u; om[e] = o;
    endtask

    always @(negedge clk) begin : cmp
        int e, xi, xd;
        bit inta, iord, xoe;
        if (!RES) begin
            pm[0] = 0; mm[0] = 0; um[0] = 0; om[0] = 0;
            chk("int_rst", INT, 1);
            chk("oe_rst", D_oe, 0);
            chk("dout_rst", D_out, 0);
        end else begin
            e = ecnt;
            if (e >= N) begin
                chk("edge_budget", e, N - 1);
            end else begin
                if (e > 0) model_step(e);
                xi = (e == 0) ? 1 :
                     !((pm[e-1] & mm[e-1][0]) | (um[e-1] & mm[e-1][1]));
                chk("int", INT, xi);
                inta = !(IORQ | M1);
                iord = !(IORQ | RD);
                xoe = inta || (iord && (A == 8'h21 || A == 8'h22 ||
                                        (OVR_EN && A == 8'h23)));
                chk("d_oe", D_oe, xoe);
                if (xoe) begin
                    if (inta)              xd = 8'hF0 | (vec_at(ack_c) << 1);
                    else if (A == 8'h21)   xd = mm[e];
                    else if (A == 8'h22)   xd = {um[e], pm[e]};
                    else                   xd = om[e];
                    chk("d_out", D_out, xd);
                end
            end
        end
    end

    task automatic at_edge();
        @(posedge clk);
        #2;
    endtask

    // next task started lands on an edge count congruent to m
    task automatic wait_mod(int m);
        do at_edge(); while (ecnt % TD != (m + TD - 1) % TD);
    endtask

    task automatic wait_edge(int n);
        do at_edge(); while (ecnt < n - 1);
    endtask

    task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
        int c;
        at_edge();
        A = a; D_in = d; IORQ = 0; WR = 0;
        c = ecnt;
        evw[c+3] = 1; evwa[c+3] = a; evwd[c+3] = d;
        repeat (4) @(posedge clk);
        #2;
        IORQ = 1; WR = 1;
    endtask

    task automatic io_rd(input logic [7:0] a, output int v, output int oe);
        int d;
        at_edge();
        A = a; IORQ = 0; RD = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        v = D_out; oe = D_oe;
        @(posedge clk);
        #2;
        d = ecnt;
        IORQ = 1; RD = 1;
        if (a == 8'h23) evr[d+3] = 1;
    endtask

    task automatic ack(output int v, output int oe);
        int d;
        at_edge();
        ack_c = ecnt;
        M1 = 0; IORQ = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        v = D_out; oe = D_oe;
        @(posedge clk);
        #2;
        d = ecnt;
        M1 = 1; IORQ = 1;
        eva[d+3] = 1; evac[d+3] = ack_c;
    endtask

    task automatic set_u(input bit v);
        int c;
        at_edge();
        U_INT = v;
        c = ecnt;
        evu[c+2] = 1; evuv[c+2] = v;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int v, oe, t0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 RES = 1;

        // enable timer, first tick at edge 16, INT low from edge 17
        io_wr(8'h21, 8'h01);
        wait_edge(18);
        @(negedge clk);
        chk("t1_int_low", INT, 0);
        io_rd(8'h22, v, oe);
        chk("t1_stat", v, 8'h01);
        chk("t1_stat_oe", oe, 1);

        // acknowledge the timer
        wait_mod(1);
        ack(v, oe);
        chk("t2_vec", v, 8'hF0);
        chk("t2_vec_oe", oe, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t2_int_high", INT, 1);
        io_rd(8'h22, v, oe);
        chk("t2_stat_clr", v, 8'h00);

        // both sources pending: timer first, then UART
        io_wr(8'h21, 8'h03);
        set_u(1);
        wait_mod(1);
        ack(v, oe);
        chk("t3_vec_timer", v, 8'hF0);
        wait_mod(9);
        ack(v, oe);
        chk("t3_vec_uart", v, 8'hF2);
        @(negedge clk);
        chk("t3_int_held", INT, 0);
        io_wr(8'h21, 8'h02);
        @(negedge clk);
        chk("t3_int_uart", INT, 0);
        set_u(0);
        repeat (4) at_edge();
        @(negedge clk);
        chk("t3_int_release", INT, 1);

        // masking a pending timer
        io_wr(8'h21, 8'h01);
        @(negedge clk);
        chk("t4_int_on", INT, 0);
        io_wr(8'h21, 8'h00);
        @(negedge clk);
        chk("t4_int_masked", INT, 1);
        io_wr(8'h21, 8'h01);
        @(negedge clk);
        chk("t4_int_unmasked", INT, 0);
        io_wr(8'h22, 8'hFE);
        io_rd(8'h22, v, oe);
        chk("t4_stat_ignored", v, 8'h01);
        io_rd(8'h21, v, oe);
        chk("t4_mask_read", v, 8'h01);
        wait_mod(1);
        io_wr(8'h22, 8'h01);
        io_rd(8'h22, v, oe);
        chk("t4_w1c", v, 8'h00);
        chk("t4_int_w1c", INT, 1);

        // W1C landing on the tick edge
        wait_mod(13);
        io_wr(8'h22, 8'h01);
        io_rd(8'h22, v, oe);
        chk("t5_tick_wins", v, 8'h01);

        // overrun counter
        wait_mod(1);
        io_wr(8'h22, 8'h01);
        io_rd(8'h23, v, oe);
        if (OVR_EN) begin
            t0 = (ecnt / TD + 1) * TD;
            wait_edge(t0 + 33);
            io_rd(8'h23, v, oe);
            chk("t6_ovr_2", v, 8'h02);
            io_rd(8'h23, v, oe);
            chk("t6_ovr_clr", v, 8'h00);
            repeat (20 * TD) at_edge();
            io_rd(8'h23, v, oe);
            chk("t6_ovr_sat", v, 8'h0F);
        end else begin
            chk("t6_ovr_oe", oe, 0);
        end

        // reset in the middle of an acknowledge
        at_edge();
        ack_c = ecnt;
        M1 = 0; IORQ = 0;
        repeat (2) @(posedge clk);
        #3 RES = 0;
        #1;
        chk("t7_oe_drop", D_oe, 0);
        chk("t7_int_rst", INT, 1);
        model_reset();
        M1 = 1; IORQ = 1;
        repeat (2) @(posedge clk);
        #2 RES = 1;
        io_rd(8'h21, v, oe);
        chk("t7_mask_rst", v, 8'h00);
        io_rd(8'h22, v, oe);
        chk("t7_stat_rst", v, 8'h00);
        repeat (20) at_edge();
        io_rd(8'h22, v, oe);
        chk("t7_timer_runs", v, 8'h01);

        repeat (4) at_edge();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
